// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg
//   Shared definitions for the handshaked pipeline stage buffer.
//   pipe_state_t : occupancy state of a stage buffer
//                  EMPTY - no live entry
//                  FULL  - main entry live
//                  SKIDF - main and skid entries live (skid builds only)
//   PIPE_CNT_W_DEFAULT : default width of the per-stage stall counter
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKIDF = 2'd2
  } pipe_state_t;

  localparam int PIPE_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// pipe_sat_counter
//   Saturating up-counter. Counts once per clock while inc is high and
//   holds at all-ones instead of wrapping. Cleared only by reset.
//   Ports:
//     clk    in   clock, rising edge
//     reset  in   asynchronous, active-high clear
//     inc    in   count enable for this cycle
//     count  out  W-bit saturating count
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = (count == {W{1'b1}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Handshaked pipeline stage buffer carrying one packed stage payload.
//   Sits between two adjacent pipeline stages; the payload struct is cast
//   to and from logic [WIDTH-1:0] by the instantiating stage.
//
//   Handshake: a beat moves across a port on a rising edge where both
//   valid and ready are high on that port. valid never depends on ready of
//   the same port, and once out_valid is high the entry and out_data stay
//   put until out_ready takes it (or flush/reset kills it).
//
//   Parameters:
//     WIDTH  payload width in bits
//     SKID   0: single entry, in_ready follows out_ready combinationally
//            1: main + skid entry, in_ready derived from registered state
//     CNT_W  stall counter width
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   asynchronous, active-high reset
//     flush      in   synchronous kill of all held entries
//     in_valid   in   upstream presents in_data
//     in_ready   out  stage accepts in_data this cycle
//     in_data    in   upstream payload
//     out_valid  out  out_data holds a live entry
//     out_ready  in   downstream consumes out_data this cycle
//     out_data   out  payload of the main entry
//     stall_cnt  out  saturating count of cycles with out_valid & !out_ready
//     dbg_state  out  current occupancy state, for observation only
module pipe_stage_buf
  import pipe_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SKID  = 0,
  parameter int CNT_W = PIPE_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output pipe_state_t      dbg_state
);

  pipe_state_t      state;
  pipe_state_t      state_next;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_xfer;
  logic             load_main;
  logic             skid_to_main;
  logic             stall;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign dbg_state = state;
  assign in_xfer   = in_valid && in_ready;
  assign stall     = out_valid && !out_ready;

  // Ready generation. Flush always forces in_ready low so nothing is
  // accepted into a buffer that is being emptied.
  generate
    if (SKID != 0) begin : g_ready_reg
      // Only the state flop and flush feed in_ready; out_ready does not.
      assign in_ready = (state != SKIDF) && !flush;
    end else begin : g_ready_pass
      assign in_ready = ((state == EMPTY) || out_ready) && !flush;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and data-path steering.
  always_comb begin
    state_next   = state;
    load_main    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          load_main  = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          // Main drains this cycle; refill it directly if a beat arrives.
          if (in_xfer) begin
            load_main = 1'b1;
          end else begin
            state_next = EMPTY;
          end
        end else if (in_xfer && (SKID != 0)) begin
          // Downstream stalled but in_ready was still high: park the
          // beat in the skid entry (captured in the skid generate block).
          state_next = SKIDF;
        end
      end
      SKIDF: begin
        if (out_ready) begin
          skid_to_main = 1'b1;
          state_next   = FULL;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
    // Flush wins over every transition; an output transfer in this cycle
    // still completes because out_valid/out_data are unaffected until the
    // edge.
    if (flush) begin
      state_next = EMPTY;
    end
  end

  // Skid entry, only built when SKID is enabled.
  generate
    if (SKID != 0) begin : g_skid
      logic skid_load;

      assign skid_load = (state == FULL) && !out_ready && in_xfer;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          skid_q <= '0;
        end else if (skid_load) begin
          skid_q <= in_data;
        end
      end
    end else begin : g_no_skid
      assign skid_q = '0;
    end
  endgenerate

  // Main entry. Not cleared by flush: out_data is don't-care while
  // out_valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
    end else if (load_main) begin
      main_q <= in_data;
    end else if (skid_to_main) begin
      main_q <= skid_q;
    end
  end

  // Stall counter: backpressure cycles seen by this stage.
  pipe_sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stall),
    .count(stall_cnt)
  );

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage buffer replacing the plain IF/ID, ID/EX, EX/MEM and MEM/WB struct registers of the RISC-V core with a handshaked stage. It carries one packed stage payload of WIDTH bits and adds a valid/ready handshake, synchronous flush, an optional skid entry that fully registers the ready path, and a saturating stall counter. Instances sit between adjacent pipeline stages. Each is sized with WIDTH = $bits() of the matching Pipe_Buf_Reg_PKG struct.

## Interface
- WIDTH, 32: payload width in bits (≥1).
- SKID, 0: 0 = single entry, ready passes through combinationally; 1 = two entries (main + skid), in_ready registered.
- CNT_W, 16: stall counter width (≥1).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of held contents (branch/jump redirect).
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  stage accepts in_data this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a live entry.
- out_ready  in  1  downstream consumes out_data this cycle.
- out_data  out  WIDTH  payload of the main entry.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid & !out_ready.

## Operation
- Transfers: input when in_valid & in_ready; output when out_valid & out_ready. Data never reorders, duplicates or drops, except by flush.
- States: EMPTY, FULL, and SKIDF (SKID=1 only; main and skid both occupied).
- EMPTY: in_ready=1, out_valid=0. An input transfer loads main and moves to FULL.
- FULL, out_valid=1:
  - out_ready & in_valid: main <= in_data, stay FULL.
  - out_ready & !in_valid: go to EMPTY.
  - !out_ready with SKID=0: in_ready=0, hold.
  - !out_ready & in_valid with SKID=1: skid <= in_data, go to SKIDF.
- SKIDF: in_ready=0, out_valid=1. out_ready moves skid to main and goes to FULL.
- in_ready:
  - SKID=0: (state==EMPTY | out_ready) & !flush.
  - SKID=1: (state!=SKIDF) & !flush. The state term comes from a flop.
- flush overrides all transitions:
  - Next state is EMPTY and all entries are invalidated.
  - in_ready is forced to 0, so an in_valid in the same cycle is not accepted.
  - An output transfer in the flush cycle still completes.
- Data registers are not cleared by flush. out_data is don't-care while out_valid=0.
- stall_cnt:
  - Increments each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset; unaffected by flush.

## Timing
- Reset values: state EMPTY, out_valid=0, out_data=0, skid data=0, stall_cnt=0. in_ready=1 while reset is high and flush is low.
- Reset is asynchronous. Asserting it mid-transfer discards all entries immediately, with no wait for a clock edge.
- Latency: in_data accepted at edge N appears on out_data with out_valid=1 after edge N, i.e. one cycle.
- Throughput: one transfer per cycle with continuous out_ready, for either SKID value.
- SKID=1 absorbs exactly one extra beat after out_ready drops. in_ready falls one cycle after out_ready falls.
- Combinational paths:
  - SKID=0: out_ready→in_ready and flush→in_ready.
  - SKID=1: flush→in_ready only.
- No path exists from in_valid to out_valid or from in_data to out_data.

## Structure
- Shared package pipe_stage_pkg:
  - typedef enum logic [1:0] pipe_state_t {EMPTY, FULL, SKIDF}.
  - localparam default CNT_W.
- Payload structs stay in Pipe_Buf_Reg_PKG. Instantiating stages cast to and from logic [WIDTH-1:0].
- Sub-module pipe_sat_counter, parameter W: increments on inc, saturates at all-ones, asynchronous reset. Used for stall_cnt.
- The skid register and the SKIDF state are generated only when SKID=1.

## Test plan
- Reset, then push 0x11,0x22,0x33 on consecutive cycles with out_ready=1:
  - Output is 0x11,0x22,0x33, each one cycle after acceptance.
  - in_ready stays 1 and stall_cnt=0.
- SKID=0, full with 0xAA, out_ready=0 for 3 cycles while in_valid=1 with 0xBB:
  - in_ready=0 throughout and out_data stays 0xAA; stall_cnt=3.
  - When out_ready rises, 0xAA is consumed and 0xBB is accepted in that same cycle.
- SKID=1, same stimulus:
  - 0xBB is captured into skid and in_ready drops the following cycle.
  - When out_ready rises, the output is 0xAA then 0xBB with no loss.
- flush in SKIDF with in_valid=1 (0xCC):
  - Next cycle out_valid=0, in_ready=1.
  - 0xCC never appears on the output; stall_cnt is unchanged by the flush.
- CNT_W=3, hold out_ready=0 for 10 cycles: stall_cnt reaches 7 and stays at 7.
- Assert reset asynchronously mid-cycle while FULL: out_valid=0 and stall_cnt=0 before the next clock edge.
